// File: rtl/dcache_arb_pkg.sv
// Shared types and helpers for the data-cache port arbiter.
package dcache_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Number of low address bits covered by one byte-mask word.
  function automatic int unsigned align_bits(input int unsigned mask_width);
    int unsigned bits;
    if (mask_width > 1) bits = 32'($clog2(mask_width));
    else                bits = 0;
    return bits;
  endfunction

endpackage

// File: rtl/dcache_arb_picker.sv
// Combinational one-hot picker: first valid index at or after ptr, wrapping.
module dcache_arb_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// N-requester arbiter onto the single data-cache port; one outstanding access.
// Define DCACHE_ARB_RR_EN for round-robin selection, otherwise fixed priority.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][MASK_WIDTH-1:0]   req_rmask,
  input  logic [NUM_REQ-1:0][MASK_WIDTH-1:0]   req_wmask,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   req_gnt,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_rdata,
  output logic [MASK_WIDTH-1:0]                dmem_rmask,
  output logic [MASK_WIDTH-1:0]                dmem_wmask,
  output logic [ADDR_WIDTH-1:0]                dmem_addr,
  output logic [DATA_WIDTH-1:0]                dmem_wdata,
  input  logic [DATA_WIDTH-1:0]                dmem_rdata,
  input  logic                                 dmem_resp
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned ALIGN_W = align_bits(MASK_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_W;

  arb_state_e              state_q, state_d;
  logic                    take;
  logic [NUM_REQ-1:0]      win_oh;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        pick_ptr;
  logic [PTR_W-1:0]        owner_q;
  logic [MASK_WIDTH-1:0]   rmask_q, wmask_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  dcache_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .grant (win_oh)
  );

  // One-hot winner to index.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
  end

`ifdef DCACHE_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (take) begin
      rr_ptr_q <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  assign pick_ptr = rr_ptr_q;
`else
  assign pick_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, grant and response strobes; reset suppresses both strobes.
  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    req_gnt    = '0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          take    = 1'b1;
          req_gnt = win_oh;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          resp_valid[owner_q] = 1'b1;
          state_d             = IDLE;
        end
      end
    endcase
    if (rst) begin
      take       = 1'b0;
      req_gnt    = '0;
      resp_valid = '0;
    end
  end

  // Capture the winner; a request carrying any write byte is a pure write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rmask_q <= '0;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= '0;
    end else if (take) begin
      rmask_q <= (|req_wmask[win_idx]) ? '0 : req_rmask[win_idx];
      wmask_q <= req_wmask[win_idx];
      addr_q  <= req_addr[win_idx] & ALIGN_MASK;
      wdata_q <= req_wdata[win_idx];
      owner_q <= win_idx;
    end
  end

  assign dmem_rmask = (state_q == BUSY) ? rmask_q : '0;
  assign dmem_wmask = (state_q == BUSY) ? wmask_q : '0;
  assign dmem_addr  = (state_q == BUSY) ? addr_q  : '0;
  assign dmem_wdata = (state_q == BUSY) ? wdata_q : '0;
  assign resp_rdata = dmem_rdata;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter (NUM_REQ=2, 32-bit data).
module tb_dcache_port_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0][MW-1:0]   req_rmask;
  logic [N-1:0][MW-1:0]   req_wmask;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0]           req_gnt;
  logic [N-1:0]           resp_valid;
  logic [DW-1:0]          resp_rdata;
  logic [MW-1:0]          dmem_rmask;
  logic [MW-1:0]          dmem_wmask;
  logic [AW-1:0]          dmem_addr;
  logic [DW-1:0]          dmem_wdata;
  logic [DW-1:0]          dmem_rdata;
  logic                   dmem_resp;

  int checks = 0;
  int errors = 0;

  dcache_port_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MASK_WIDTH (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rmask  (req_rmask),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_gnt    (req_gnt),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dmem_idle(input string tag);
    chk({tag, "_rmask"}, 64'(dmem_rmask), 64'h0);
    chk({tag, "_wmask"}, 64'(dmem_wmask), 64'h0);
    chk({tag, "_addr"},  64'(dmem_addr),  64'h0);
    chk({tag, "_wdata"}, 64'(dmem_wdata), 64'h0);
  endtask

  logic [N-1:0] exp_g;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_rmask  = '0;
    req_wmask  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    dmem_rdata = '0;
    dmem_resp  = 1'b0;

    // Reset: grant suppressed even with requests pending.
    cyc();
    cyc();
    req_valid = 2'b11;
    #1;
    chk("rst_gnt", 64'(req_gnt), 64'h0);
    chk("rst_resp", 64'(resp_valid), 64'h0);
    chk_dmem_idle("rst");

    // Single load from requester 1, 3-cycle cache.
    cyc();
    rst          = 1'b0;
    req_valid    = 2'b10;
    req_rmask[1] = 4'hF;
    req_addr[1]  = 32'h0000_1003;
    req_wdata[1] = 32'h1234_5678;
    #1;
    chk("ld_gnt", 64'(req_gnt), 64'h2);
    cyc();
    req_valid = 2'b00;
    req_addr[1] = 32'hFFFF_FFFF;
    #1;
    chk("ld_t1_addr", 64'(dmem_addr), 64'h1000);
    chk("ld_t1_rmask", 64'(dmem_rmask), 64'hF);
    chk("ld_t1_wmask", 64'(dmem_wmask), 64'h0);
    chk("ld_t1_gnt", 64'(req_gnt), 64'h0);
    cyc();
    #1;
    chk("ld_t2_addr", 64'(dmem_addr), 64'h1000);
    chk("ld_t2_resp", 64'(resp_valid), 64'h0);
    cyc();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_r_resp", 64'(resp_valid), 64'h2);
    chk("ld_r_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
    chk("ld_r_addr", 64'(dmem_addr), 64'h1000);
    chk("ld_r_rmask", 64'(dmem_rmask), 64'hF);
    cyc();
    dmem_resp = 1'b0;
    #1;
    chk("ld_r1_resp", 64'(resp_valid), 64'h0);
    chk_dmem_idle("ld_r1");

    // Both requesters pending, 1-cycle cache; req 0 carries a write+read mask.
    req_rmask[0] = 4'hF;
    req_wmask[0] = 4'b0011;
    req_addr[0]  = 32'h0000_2005;
    req_wdata[0] = 32'hCAFE_F00D;
    req_rmask[1] = 4'hF;
    req_wmask[1] = 4'h0;
    req_addr[1]  = 32'h0000_3000;
    req_valid    = 2'b11;
    dmem_resp    = 1'b1;
    dmem_rdata   = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
`ifdef DCACHE_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk($sformatf("arb_gnt%0d", k), 64'(req_gnt), 64'(exp_g));
      cyc();
      #1;
      chk($sformatf("arb_resp%0d", k), 64'(resp_valid), 64'(exp_g));
      if (exp_g == 2'b01) begin
        chk($sformatf("arb_wmask%0d", k), 64'(dmem_wmask), 64'h3);
        chk($sformatf("arb_rmask%0d", k), 64'(dmem_rmask), 64'h0);
        chk($sformatf("arb_addr%0d", k), 64'(dmem_addr), 64'h2004);
        chk($sformatf("arb_wdata%0d", k), 64'(dmem_wdata), 64'hCAFE_F00D);
      end else begin
        chk($sformatf("arb_rmask%0d", k), 64'(dmem_rmask), 64'hF);
        chk($sformatf("arb_addr%0d", k), 64'(dmem_addr), 64'h3000);
      end
      cyc();
    end

    // Reset in BUSY with a same-cycle cache response.
    req_valid = 2'b10;
    dmem_resp = 1'b0;
    req_wdata[1] = 32'h1234_5678;
    #1;
    chk("rb_gnt", 64'(req_gnt), 64'h2);
    cyc();
    req_valid = 2'b00;
    rst       = 1'b1;
    dmem_resp = 1'b1;
    #1;
    chk("rb_resp", 64'(resp_valid), 64'h0);
    cyc();
    rst       = 1'b0;
    dmem_resp = 1'b0;
    dmem_rdata = '0;
    #1;
    chk("rb_after_resp", 64'(resp_valid), 64'h0);
    chk("rb_after_gnt", 64'(req_gnt), 64'h0);
    chk_dmem_idle("rb_after");
    req_valid = 2'b01;
    #1;
    chk("rb_idle_gnt", 64'(req_gnt), 64'h1);
    cyc();
    req_valid  = 2'b00;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("rb_next_resp", 64'(resp_valid), 64'h1);
    chk("rb_next_rdata", 64'(resp_rdata), 64'h5555_AAAA);
    cyc();
    dmem_resp = 1'b0;

    // Spurious response in IDLE.
    dmem_resp = 1'b1;
    #1;
    chk("sp_resp", 64'(resp_valid), 64'h0);
    cyc();
    #1;
    chk("sp_resp2", 64'(resp_valid), 64'h0);
    chk_dmem_idle("sp");

    // Zero-mask request is still granted and forwarded.
    dmem_resp    = 1'b0;
    req_rmask[1] = 4'h0;
    req_wmask[1] = 4'h0;
    req_addr[1]  = 32'h0000_0046;
    req_valid    = 2'b10;
    #1;
    chk("zm_gnt", 64'(req_gnt), 64'h2);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("zm_addr", 64'(dmem_addr), 64'h44);
    chk("zm_rmask", 64'(dmem_rmask), 64'h0);
    chk("zm_wmask", 64'(dmem_wmask), 64'h0);
    cyc();
    dmem_resp = 1'b1;
    #1;
    chk("zm_resp", 64'(resp_valid), 64'h2);
    cyc();
    dmem_resp = 1'b0;
    #1;
    chk("zm_done_addr", 64'(dmem_addr), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
